// File: rtl/mem_pkg.sv
// Shared types and access-type encodings for the memory port arbiter.
package mem_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   localparam logic [2:0] LS_LB  = 3'd0;
   localparam logic [2:0] LS_LBU = 3'd1;
   localparam logic [2:0] LS_LH  = 3'd2;
   localparam logic [2:0] LS_LHU = 3'd3;
   localparam logic [2:0] LS_LW  = 3'd4;
   localparam logic [2:0] LS_SB  = 3'd5;
   localparam logic [2:0] LS_SH  = 3'd6;
   localparam logic [2:0] LS_SW  = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFETCH = 2'd1,
      DATA   = 2'd2
   } arb_state_t;

   // Access code does not match the direction of the request.
   function automatic logic ls_class_bad(input logic [2:0] code, input logic is_store);
      return is_store ? (code < LS_SB) : (code > LS_LW);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_valid;

   logic          d_memread;
   logic          d_memwrite;
   logic [2:0]    d_load_store;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_done;
   logic          misalign;

   logic          stall_if;
   logic          stall_mem;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_wstrb;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport slave (
      input  if_req, if_addr, d_memread, d_memwrite, d_load_store, d_addr, d_wdata,
             mem_rdata, mem_ready,
      output if_rdata, if_valid, d_rdata, d_done, misalign, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, d_memread, d_memwrite, d_load_store, d_addr, d_wdata,
             mem_rdata, mem_ready,
      input  if_rdata, if_valid, d_rdata, d_done, misalign, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter_lsu_align.sv
// Byte-lane strobes, store replication, alignment check and load extension.
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  ls_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  rd_ls_i,
   input  logic [1:0]  rd_addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_rep_o,
   output logic [31:0] rdata_ext_o,
   output logic        misaligned_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      wstrb_o      = 4'b0000;
      wdata_rep_o  = wdata_i;
      misaligned_o = 1'b0;
      case (ls_i)
         LS_SB: begin
            wstrb_o     = 4'b0001 << addr_lo_i;
            wdata_rep_o = {4{wdata_i[7:0]}};
         end
         LS_SH: begin
            wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_rep_o  = {2{wdata_i[15:0]}};
            misaligned_o = addr_lo_i[0];
         end
         LS_SW: begin
            wstrb_o      = 4'b1111;
            misaligned_o = |addr_lo_i;
         end
         LS_LH, LS_LHU: misaligned_o = addr_lo_i[0];
         LS_LW:         misaligned_o = |addr_lo_i;
         default: ;
      endcase
   end

   always_comb begin
      case (rd_addr_lo_i)
         2'd0:    rd_byte = rdata_i[7:0];
         2'd1:    rd_byte = rdata_i[15:8];
         2'd2:    rd_byte = rdata_i[23:16];
         default: rd_byte = rdata_i[31:24];
      endcase
      rd_half = rd_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (rd_ls_i)
         LS_LB:   rdata_ext_o = {{24{rd_byte[7]}}, rd_byte};
         LS_LBU:  rdata_ext_o = {24'd0, rd_byte};
         LS_LH:   rdata_ext_o = {{16{rd_half[15]}}, rd_half};
         LS_LHU:  rdata_ext_o = {16'd0, rd_half};
         default: rdata_ext_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data side beats fetch, one transaction in flight.
// state  | meaning
// IDLE   | nothing outstanding
// IFETCH | fetch outstanding on the memory port
// DATA   | load or store outstanding on the memory port
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   mem_port_arbiter_if.slave bus
);

   arb_state_t            state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wstrb_q, mem_wstrb_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic                  if_valid_q, if_valid_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  d_done_q, d_done_d;
   logic                  misalign_q, misalign_d;
   logic [2:0]            ls_q, ls_d;
   logic [1:0]            alo_q, alo_d;

   logic                  data_pend, fetch_pend, is_store, reject;
   logic [3:0]            al_wstrb;
   logic [31:0]           al_wdata, al_rdata;
   logic                  al_mis;
   logic [1:0]            unused_if_lo;

   assign unused_if_lo = bus.if_addr[1:0];

   lsu_align u_align (
      .ls_i         (bus.d_load_store),
      .addr_lo_i    (bus.d_addr[1:0]),
      .wdata_i      (bus.d_wdata),
      .rd_ls_i      (ls_q),
      .rd_addr_lo_i (alo_q),
      .rdata_i      (bus.mem_rdata),
      .wstrb_o      (al_wstrb),
      .wdata_rep_o  (al_wdata),
      .rdata_ext_o  (al_rdata),
      .misaligned_o (al_mis)
   );

   // A requester that sees its pulse still holds the old request for that cycle.
   assign data_pend  = (bus.d_memread | bus.d_memwrite) & ~d_done_q;
   assign fetch_pend = bus.if_req & ~if_valid_q;
   assign is_store   = bus.d_memwrite;
   assign reject     = al_mis | ls_class_bad(bus.d_load_store, is_store);

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_rdata_d  = if_rdata_q;
      if_valid_d  = 1'b0;
      d_rdata_d   = d_rdata_q;
      d_done_d    = 1'b0;
      misalign_d  = 1'b0;
      ls_d        = ls_q;
      alo_d       = alo_q;
      case (state_q)
         IDLE: begin
            if (data_pend) begin
               ls_d  = bus.d_load_store;
               alo_d = bus.d_addr[1:0];
               if (reject) begin
                  d_done_d   = 1'b1;
                  misalign_d = 1'b1;
                  d_rdata_d  = '0;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_addr_d  = {bus.d_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata_d = al_wdata;
                  mem_wstrb_d = is_store ? al_wstrb : 4'b0000;
                  state_d     = DATA;
               end
            end else if (fetch_pend) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               mem_addr_d  = {bus.if_addr[ADDR_WIDTH-1:2], 2'b00};
               state_d     = IFETCH;
            end
         end
         IFETCH: begin
            if (bus.mem_ready) begin
               mem_req_d  = 1'b0;
               if_rdata_d = bus.mem_rdata;
               if_valid_d = 1'b1;
               state_d    = IDLE;
            end
         end
         DATA: begin
            if (bus.mem_ready) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               if (!mem_we_q) d_rdata_d = al_rdata;
               d_done_d    = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         if_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         d_rdata_q   <= '0;
         d_done_q    <= 1'b0;
         misalign_q  <= 1'b0;
         ls_q        <= LS_LW;
         alo_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         if_valid_q  <= if_valid_d;
         d_rdata_q   <= d_rdata_d;
         d_done_q    <= d_done_d;
         misalign_q  <= misalign_d;
         ls_q        <= ls_d;
         alo_q       <= alo_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_done    = d_done_q;
   assign bus.misalign  = misalign_q;
   assign bus.stall_mem = (bus.d_memread | bus.d_memwrite) & ~d_done_q;
   assign bus.stall_if  = bus.if_req & ~if_valid_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency memory between instruction fetch (IF) and the MEM-stage load/store path. It uses a 3-state FSM with data-side priority and one outstanding transaction. It generates byte strobes, lane replication and load sign/zero extension from the 3-bit load_store code carried down the pipeline. It drives stall_if and stall_mem into the hazard/flush logic.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held until if_valid
if_addr  input  ADDR_WIDTH  fetch byte address; [1:0] ignored
if_rdata  output  DATA_WIDTH  fetched instruction; valid when if_valid=1
if_valid  output  1  one-cycle completion pulse for fetch
d_memread  input  1  MEM-stage load request
d_memwrite  input  1  MEM-stage store request
d_load_store  input  3  access type (encoding in Decomposition)
d_addr  input  ADDR_WIDTH  data byte address
d_wdata  input  DATA_WIDTH  store data, right-aligned
d_rdata  output  DATA_WIDTH  aligned, extended load data
d_done  output  1  one-cycle data completion pulse
misalign  output  1  one-cycle pulse, coincident with d_done, for a rejected access
stall_if  output  1  fetch pending, not complete this cycle
stall_mem  output  1  data access pending, not complete this cycle
mem_req  output  1  memory request; held until mem_ready
mem_we  output  1  write enable
mem_addr  output  ADDR_WIDTH  word address, {addr[31:2],2'b00}
mem_wdata  output  DATA_WIDTH  lane-replicated store data
mem_wstrb  output  4  byte-lane write strobes
mem_rdata  input  DATA_WIDTH  memory read data; valid with mem_ready
mem_ready  input  1  completion handshake; any latency of 1 cycle or more

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - mem_req, mem_we, mem_wstrb, if_valid, d_done and misalign go to 0 immediately.
  - if_rdata and d_rdata go to 0.
  - Reset mid-transaction abandons it; no d_done or if_valid is produced for it.
- States:
  - IDLE: nothing outstanding.
  - IFETCH: fetch outstanding.
  - DATA: load or store outstanding.
- IDLE grant:
  - A data request is d_memread|d_memwrite.
  - A data request beats if_req.
  - If both d_memread and d_memwrite are 1, treat the request as a store.
- Data grant, legal access:
  - Register mem_req=1, mem_we=d_memwrite, mem_addr, mem_wdata and mem_wstrb.
  - Go to DATA.
- Data grant, misaligned access:
  - Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - No mem_req is issued.
  - Next cycle: d_done=1, misalign=1, d_rdata=0.
  - State stays IDLE.
- Fetch grant: register mem_req=1, mem_we=0, mem_wstrb=0, mem_addr = word-aligned if_addr; go to IFETCH.
- While in IFETCH or DATA, all request outputs are held stable until mem_ready=1.
- Completion cycle (mem_ready=1), registered on that edge:
  - mem_req drops.
  - For a fetch, capture if_rdata=mem_rdata and pulse if_valid.
  - For a load, capture d_rdata = extend(mem_rdata) and pulse d_done.
  - For a store, pulse d_done; d_rdata is unchanged.
  - Return to IDLE.
- IDLE always lasts at least one cycle, so back-to-back transactions have a minimum 1-cycle gap.
- mem_ready while in IDLE is ignored.
- Latency: with mem_ready asserted one cycle after mem_req, the pulse appears 2 cycles after the request was first seen in IDLE.
- Stall outputs (combinational):
  - stall_mem = (d_memread|d_memwrite) & ~d_done.
  - stall_if = if_req & ~if_valid.
  - Requesters keep their request high while stalled.
  - Requesters must drop or change their request in the cycle after the pulse. A request still present in IDLE is a new access.
- Strobes and write data:
  - sb: mem_wstrb = 4'b0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - sh: mem_wstrb = 4'b0011<<{addr[1],1'b0}; mem_wdata = {2{wdata[15:0]}}.
  - sw: mem_wstrb = 4'b1111; mem_wdata = wdata.
- Load extraction:
  - lb/lbu select byte addr[1:0].
  - lh/lhu select halfword addr[1].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes through.
- The load_store code is latched at grant, so extraction uses the latched code and latched addr[1:0].
- Codes 5–7 on a load, or 0–4 on a store, are treated as misaligned (rejected).

Decomposition:
- Package mem_pkg:
  - LS_LB=3'd0, LS_LBU=3'd1, LS_LH=3'd2, LS_LHU=3'd3, LS_LW=3'd4, LS_SB=3'd5, LS_SH=3'd6, LS_SW=3'd7.
  - arb_state_t {IDLE, IFETCH, DATA}.
- Sub-module lsu_align (combinational):
  - Inputs: load_store, addr[1:0], wdata, rdata.
  - Outputs: wstrb, wdata_rep, rdata_ext, misaligned.
  - Instantiated once; its strobe/replication/misaligned outputs use the live grant-time d_load_store and d_addr[1:0]; its load-extension path uses the values latched at grant.

Test Plan:
- Reset: rst=0 held with if_req=1 → mem_req=0, if_valid=0; after release, first grant is a fetch to if_addr=0x0000_0010 → mem_addr=0x10, mem_we=0.
- Contention: if_req=1 and d_memread=1 (lw, addr 0x100) together in IDLE → data granted first. mem_ready after 3 cycles with rdata=0xDEAD_BEEF → d_done pulse, d_rdata=0xDEAD_BEEF, then the fetch issues after one IDLE cycle. stall_if=1 throughout.
- Byte load: lb at addr 0x103, mem_rdata=0x80FF_0000 → d_rdata=0xFFFF_FF80. lbu at 0x102 → 0x0000_00FF. lhu at 0x102 → 0x0000_80FF.
- Stores: sh at 0x202, wdata=0x1234_ABCD → mem_wstrb=4'b1100, mem_wdata=0xABCD_ABCD. sb at 0x201 → mem_wstrb=4'b0010, mem_wdata=0xCDCD_CDCD.
- Misalign: sw at 0x301 → no mem_req; next cycle d_done=1, misalign=1, d_rdata=0.
- Reset mid-transaction: rst=0 while in DATA with mem_ready=0 → mem_req drops asynchronously; after release, mem_ready=1 in IDLE is ignored and no d_done is produced.
